// File: rtl/int2half_seq_pkg.sv
// Shared fp16 definitions for the CNN datapath: field widths, bias and
// the converter's FSM encoding (the fp16 adder pulls the same constants).
package int2half_seq_pkg;

  localparam int DATA_W    = 16;
  localparam int HALF_BIAS = 15;
  localparam int EXP_W     = 5;
  localparam int MANT_W    = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/int2half_seq_if.sv
// Valid/ready bundle for int2half_seq: fixed-point word in, fp16 word out.
interface int2half_seq_if;
  import int2half_seq_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/int2half_seq.sv
// Sequential signed fixed-point to fp16 converter: normalises one bit per
// cycle, truncates the mantissa and flushes anything below the normal range to +0.
module int2half_seq
  import int2half_seq_pkg::*;
#(
  parameter int FRAC_BITS = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  int2half_seq_if.slave  bus
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] mag_q, mag_d;
  logic [3:0]        n_q, n_d;
  logic              sign_q, sign_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic [7:0]        exp_w;
  logic              exp_pos;

  // E = 30 - N - FRAC_BITS; the 8-bit window keeps the sign of a wrapped result
  assign exp_w   = 8'(2 * HALF_BIAS - FRAC_BITS) - {4'b0000, n_q};
  assign exp_pos = !exp_w[7] && (exp_w != 8'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mag_q   <= '0;
      n_q     <= '0;
      sign_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      n_q     <= n_d;
      sign_q  <= sign_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    n_d     = n_q;
    sign_d  = sign_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sign_d = bus.in_data[DATA_W-1];
          // -32768 negates to itself, which as unsigned is exactly 0x8000
          mag_d  = bus.in_data[DATA_W-1] ? (~bus.in_data + 16'd1) : bus.in_data;
          n_d    = '0;
          if (bus.in_data == '0) begin
            out_d   = '0;
            state_d = DONE;
          end else begin
            state_d = NORM;
          end
        end
      end
      NORM: begin
        if (mag_q[DATA_W-1]) begin
          out_d   = exp_pos ? {sign_q, exp_w[EXP_W-1:0], mag_q[DATA_W-2 -: MANT_W]} : '0;
          state_d = DONE;
        end else begin
          mag_d = mag_q << 1;
          n_d   = n_q + 4'd1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_data  = out_q;

endmodule

// File: tb/tb_int2half_seq.sv
// Scoreboard bench for int2half_seq: three lockstep instances (FRAC_BITS 0, 8, 15)
// share one stimulus stream and are checked against an arithmetic fp16 model.
module tb_int2half_seq;

  typedef struct {
    logic [15:0] data;
    logic [15:0] exp0;
    logic [15:0] exp8;
    logic [15:0] exp15;
    int          due;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  exp_t        sb[$];
  int          hold_low      = 0;
  int          ready_pct     = 60;
  bit          holding       = 1'b0;
  bit          just_consumed = 1'b0;
  logic [15:0] held          = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int2half_seq_if bus0 ();
  int2half_seq_if bus8 ();
  int2half_seq_if bus15 ();

  assign bus8.in_valid   = bus0.in_valid;
  assign bus8.in_data    = bus0.in_data;
  assign bus8.out_ready  = bus0.out_ready;
  assign bus15.in_valid  = bus0.in_valid;
  assign bus15.in_data   = bus0.in_data;
  assign bus15.out_ready = bus0.out_ready;

  int2half_seq #(.FRAC_BITS(0))  u_dut0  (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  int2half_seq #(.FRAC_BITS(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
  int2half_seq #(.FRAC_BITS(15)) u_dut15 (.clk(clk), .rst_n(rst_n), .bus(bus15.slave));

  function automatic int floorLog2(input int m);
    return $clog2(m + 1) - 1;
  endfunction

  // value = in_data / 2^fb; fp16 of that with truncated mantissa and flush-to-zero
  function automatic logic [15:0] refHalf(input logic [15:0] d, input int fb);
    int v, mag, p, e, mant;
    logic [15:0] r;
    v   = int'($signed(d));
    mag = (v < 0) ? -v : v;
    if (mag == 0) return 16'h0000;
    p    = floorLog2(mag);
    e    = p + 15 - fb;
    if (e <= 0) return 16'h0000;
    mant = ((mag - (1 << p)) * 1024) / (1 << p);
    r    = {(v < 0), 5'(e), 10'(mant)};
    return r;
  endfunction

  function automatic int latencyOf(input logic [15:0] d);
    int v, mag;
    v   = int'($signed(d));
    mag = (v < 0) ? -v : v;
    if (mag == 0) return 1;
    return (15 - floorLog2(mag)) + 2;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Present d once in_ready is seen; junk in_valid pulses fill the busy cycles
  task automatic applyStimulus(input logic [15:0] d);
    int   guard;
    exp_t e;
    guard = 0;
    @(negedge clk);
    while (!bus0.in_ready && guard < 200) begin
      bus0.in_valid = 1'($urandom_range(0, 1));
      bus0.in_data  = 16'($urandom);
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      checkOutput("accept_timeout", 0, 1);
      bus0.in_valid = 1'b0;
      return;
    end
    bus0.in_valid = 1'b1;
    bus0.in_data  = d;
    e.data  = d;
    e.exp0  = refHalf(d, 0);
    e.exp8  = refHalf(d, 8);
    e.exp15 = refHalf(d, 15);
    e.due   = cyc + 1 + latencyOf(d);
    sb.push_back(e);
    @(negedge clk);
    bus0.in_valid = 1'b0;
    bus0.in_data  = 16'($urandom);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((sb.size() > 0 || holding) && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (g >= 500) checkOutput("drain_timeout", sb.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  // Monitor: pops the scoreboard on each new result and polices the DONE hold
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      holding       = 1'b0;
      just_consumed = 1'b0;
    end else begin
      if (just_consumed) begin
        checkOutput("in_ready_after_done", int'(bus0.in_ready), 1);
        checkOutput("valid_after_done", int'(bus0.out_valid), 0);
        just_consumed = 1'b0;
      end
      if (bus0.out_valid) begin
        if (!holding) begin
          holding = 1'b1;
          held    = bus0.out_data;
          if (sb.size() == 0) begin
            checkOutput("unexpected_output", int'(bus0.out_data), -1);
          end else begin
            e = sb.pop_front();
            checkOutput($sformatf("data_fb0[%0h]", e.data), int'(bus0.out_data), int'(e.exp0));
            checkOutput($sformatf("data_fb8[%0h]", e.data), int'(bus8.out_data), int'(e.exp8));
            checkOutput($sformatf("data_fb15[%0h]", e.data), int'(bus15.out_data), int'(e.exp15));
            checkOutput($sformatf("latency[%0h]", e.data), cyc + 1, e.due);
          end
        end else begin
          checkOutput("stall_data_stable", int'(bus0.out_data), int'(held));
        end
        checkOutput("in_ready_in_done", int'(bus0.in_ready), 0);
        if (hold_low > 0) begin
          bus0.out_ready = 1'b0;
          hold_low--;
        end else begin
          bus0.out_ready = ($urandom_range(0, 99) < ready_pct);
        end
        if (bus0.out_ready) begin
          holding       = 1'b0;
          just_consumed = 1'b1;
        end
      end else begin
        if (holding) begin
          checkOutput("valid_dropped", 0, 1);
          holding = 1'b0;
        end
        bus0.out_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  logic [15:0] directed [10] = '{16'h0001, 16'h8000, 16'd1000, 16'd2049, 16'hFFFF,
                                 16'h0000, 16'h0180, 16'h7FFF, 16'h0000, 16'hFC18};

  initial begin
    logic [15:0] d;
    bus0.in_valid  = 1'b0;
    bus0.in_data   = '0;
    bus0.out_ready = 1'b0;

    #12;
    checkOutput("reset_in_ready", int'(bus0.in_ready), 1);
    checkOutput("reset_out_valid", int'(bus0.out_valid), 0);
    checkOutput("reset_out_data", int'(bus0.out_data), 0);
    checkOutput("reset_out_data_fb15", int'(bus15.out_data), 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (directed[i]) applyStimulus(directed[i]);
    drain();

    // Consumer stalls five cycles while the producer keeps poking in_valid
    hold_low = 5;
    applyStimulus(16'd1000);
    applyStimulus(16'hFFFF);
    drain();

    // Reset in the middle of normalising must lose the pending result
    applyStimulus(16'h0001);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midnorm_rst_out_valid", int'(bus0.out_valid), 0);
    checkOutput("midnorm_rst_out_data", int'(bus0.out_data), 0);
    checkOutput("midnorm_rst_in_ready", int'(bus0.in_ready), 1);
    sb.delete();
    holding       = 1'b0;
    just_consumed = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    checkOutput("no_stale_out_valid", int'(bus0.out_valid), 0);
    checkOutput("no_stale_in_ready", int'(bus0.in_ready), 1);

    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(0, 3))
        0: d = 16'($urandom_range(0, 255));
        1: d = -16'($urandom_range(0, 255));
        2: begin
          case ($urandom_range(0, 4))
            0: d = 16'h0000;
            1: d = 16'h0001;
            2: d = 16'hFFFF;
            3: d = 16'h8000;
            default: d = 16'h7FFF;
          endcase
        end
        default: d = 16'($urandom);
      endcase
      ready_pct = ($urandom_range(0, 3) == 0) ? 100 : 50;
      applyStimulus(d);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
